// File: rtl/rom_loader.sv
// rom_loader: writer side of the instruction ROM.
// Receives a framed byte stream (SYNC, LEN_lo, LEN_hi, LEN x 4 data bytes, [CSUM])
// and writes little-endian 32-bit words to consecutive ROM word addresses from 0.
// The core is held in reset (cpu_hold_o) until a complete, valid image is written.
//
// Optional feature: define ROM_LOADER_CSUM_EN to expect a trailing checksum byte
// (XOR of LEN_lo, LEN_hi and all data bytes). Undefined: no checksum byte.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   byte_i/_valid_i    incoming byte stream
//   byte_ready_o       loader accepts a byte (transfer on valid & ready)
//   rom_we_o           one-cycle write strobe per word
//   rom_waddr_o        ROM word address
//   rom_wdata_o        ROM write data
//   cpu_hold_o         1 = keep core in reset
//   done_o             image loaded successfully (level)
//   error_o            frame error (level)
//   words_o            words written in the current frame
module rom_loader #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned MAX_WORDS   = 4096,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              rom_we_o,
  output logic [ADDR_W-1:0] rom_waddr_o,
  output logic [31:0]       rom_wdata_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W:0]   words_o
);

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned TMO_W  = 16;
  localparam int unsigned WCNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [WCNT_W-1:0]   words_q, words_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [23:0]         buf_q, buf_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [7:0]          csum_q, csum_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;

  logic                accept;
  logic [LEN_W-1:0]    len_full;
  logic [TMO_W-1:0]    tmo_inc;
  logic                last_word;

  assign accept    = byte_valid_i & ready_q;
  assign len_full  = {byte_i, len_q[7:0]};
  assign tmo_inc   = tmo_q + TMO_W'(1);
  assign last_word = (32'(words_q) + 32'd1) == 32'(len_q);

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    ready_d = 1'b1;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    words_d = words_q;
    len_d   = len_q;
    buf_d   = buf_q;
    bcnt_d  = bcnt_q;
    csum_d  = csum_q;
    tmo_d   = '0;

    // Address advances in the cycle after each write strobe
    if (we_q) waddr_d = waddr_q + ADDR_W'(1);

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        // SYNC (re)starts a load; anything else is discarded
        if (accept && byte_i == SYNC_BYTE) begin
          state_d = S_LEN0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
          waddr_d = '0;
          words_d = '0;
          bcnt_d  = '0;
        end
      end
      S_LEN0: begin
        if (accept) begin
          len_d   = {8'h00, byte_i};
          csum_d  = byte_i;
          state_d = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d  = len_full;
          csum_d = csum_q ^ byte_i;
          bcnt_d = '0;
          if (32'(len_full) > MAX_WORDS) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (len_full == '0) begin
`ifdef ROM_LOADER_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d = csum_q ^ byte_i;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {byte_i, buf_q};
            words_d = words_q + WCNT_W'(1);
            bcnt_d  = '0;
            if (last_word) begin
`ifdef ROM_LOADER_CSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
              done_d  = 1'b1;
              hold_d  = 1'b0;
`endif
            end
          end else begin
            // Earlier bytes shift down so byte 0 lands in [7:0]
            buf_d  = {byte_i, buf_q[23:8]};
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (byte_i == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte timeout inside a frame
    if (state_q == S_LEN0 || state_q == S_LEN1 ||
        state_q == S_DATA || state_q == S_CSUM) begin
      if (!accept && TIMEOUT_CYC != 0) begin
        tmo_d = tmo_inc;
        if (32'(tmo_inc) == TIMEOUT_CYC) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          tmo_d   = '0;
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      words_q <= '0;
      len_q   <= '0;
      buf_q   <= '0;
      bcnt_q  <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      words_q <= words_d;
      len_q   <= len_d;
      buf_q   <= buf_d;
      bcnt_q  <= bcnt_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
    end
  end

  assign byte_ready_o = ready_q;
  assign rom_we_o     = we_q;
  assign rom_waddr_o  = waddr_q;
  assign rom_wdata_o  = wdata_q;
  assign cpu_hold_o   = hold_q;
  assign done_o       = done_q;
  assign error_o      = err_q;
  assign words_o      = words_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader (TIMEOUT_CYC = 16); adapts to ROM_LOADER_CSUM_EN.
module tb_rom_loader;

  localparam int unsigned ADDR_W = 12;

  logic              clk;
  logic              rst_n;
  logic [7:0]        byte_i;
  logic              byte_valid_i;
  logic              byte_ready_o;
  logic              rom_we_o;
  logic [ADDR_W-1:0] rom_waddr_o;
  logic [31:0]       rom_wdata_o;
  logic              cpu_hold_o;
  logic              done_o;
  logic              error_o;
  logic [ADDR_W:0]   words_o;

  int checks;
  int errors;

  logic [7:0]  tx_q[$];
  logic [43:0] wr_q[$];

  rom_loader #(
    .ADDR_W      (ADDR_W),
    .MAX_WORDS   (4096),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .rom_we_o     (rom_we_o),
    .rom_waddr_o  (rom_waddr_o),
    .rom_wdata_o  (rom_wdata_o),
    .cpu_hold_o   (cpu_hold_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .words_o      (words_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe as {addr, data}
  always @(negedge clk) begin
    if (rom_we_o) wr_q.push_back({rom_waddr_o, rom_wdata_o});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive tx_q back-to-back, one byte per cycle
  task automatic send_q();
    while (tx_q.size() > 0) begin
      @(negedge clk);
      byte_i       = tx_q.pop_front();
      byte_valid_i = 1'b1;
    end
    @(negedge clk);
    byte_valid_i = 1'b0;
    byte_i       = 8'h00;
  endtask

  task automatic push_frame1(input logic with_csum, input logic [7:0] csum);
    tx_q.push_back(8'hA5); tx_q.push_back(8'h02); tx_q.push_back(8'h00);
    tx_q.push_back(8'h13); tx_q.push_back(8'h05); tx_q.push_back(8'h10); tx_q.push_back(8'h00);
    tx_q.push_back(8'h93); tx_q.push_back(8'h05); tx_q.push_back(8'h15); tx_q.push_back(8'h00);
    if (with_csum) tx_q.push_back(csum);
  endtask

  task automatic check_two_writes(input string tag);
    logic [43:0] w;
    chk({tag, "_nwr"}, 64'(wr_q.size()), 64'd2);
    if (wr_q.size() >= 2) begin
      w = wr_q.pop_front();
      chk({tag, "_wr0"}, 64'(w), 64'h000_00100513);
      w = wr_q.pop_front();
      chk({tag, "_wr1"}, 64'(w), 64'h001_00150593);
    end
    wr_q.delete();
  endtask

  logic csum_en;

  initial begin
    checks = 0;
    errors = 0;
`ifdef ROM_LOADER_CSUM_EN
    csum_en = 1'b1;
`else
    csum_en = 1'b0;
`endif
    rst_n        = 1'b0;
    byte_i       = 8'h00;
    byte_valid_i = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(byte_ready_o), 64'd0);
    chk("rst_we",    64'(rom_we_o),     64'd0);
    chk("rst_addr",  64'(rom_waddr_o),  64'd0);
    chk("rst_data",  64'(rom_wdata_o),  64'd0);
    chk("rst_hold",  64'(cpu_hold_o),   64'd1);
    chk("rst_done",  64'(done_o),       64'd0);
    chk("rst_err",   64'(error_o),      64'd0);
    chk("rst_words", 64'(words_o),      64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_up", 64'(byte_ready_o), 64'd1);

    // Test 1: two-word image
    push_frame1(csum_en, 8'h87);
    send_q();
    repeat (3) @(negedge clk);
    check_two_writes("t1");
    chk("t1_done",  64'(done_o),     64'd1);
    chk("t1_hold",  64'(cpu_hold_o), 64'd0);
    chk("t1_err",   64'(error_o),    64'd0);
    chk("t1_words", 64'(words_o),    64'd2);
    chk("t1_addr",  64'(rom_waddr_o), 64'd2);

    // Test 2: bad checksum (restart from DONE)
    if (csum_en) begin
      push_frame1(1'b1, 8'h00);
      send_q();
      repeat (3) @(negedge clk);
      check_two_writes("t2");
      chk("t2_err",  64'(error_o),    64'd1);
      chk("t2_done", 64'(done_o),     64'd0);
      chk("t2_hold", 64'(cpu_hold_o), 64'd1);
    end

    // Test 3: leading junk, then a good frame
    tx_q.push_back(8'h00); tx_q.push_back(8'hFF); tx_q.push_back(8'h5A);
    push_frame1(csum_en, 8'h87);
    send_q();
    repeat (3) @(negedge clk);
    check_two_writes("t3");
    chk("t3_done",  64'(done_o),     64'd1);
    chk("t3_hold",  64'(cpu_hold_o), 64'd0);
    chk("t3_words", 64'(words_o),    64'd2);

    // Zero-length image: no writes, done
    tx_q.push_back(8'hA5); tx_q.push_back(8'h00); tx_q.push_back(8'h00);
    if (csum_en) tx_q.push_back(8'h00);
    send_q();
    repeat (3) @(negedge clk);
    chk("z_nwr",   64'(wr_q.size()), 64'd0);
    chk("z_done",  64'(done_o),      64'd1);
    chk("z_hold",  64'(cpu_hold_o),  64'd0);
    chk("z_words", 64'(words_o),     64'd0);

    // Test 4: LEN = 4097 exceeds MAX_WORDS
    tx_q.push_back(8'hA5); tx_q.push_back(8'h01); tx_q.push_back(8'h10);
    send_q();
    repeat (3) @(negedge clk);
    chk("t4_nwr",  64'(wr_q.size()), 64'd0);
    chk("t4_err",  64'(error_o),     64'd1);
    chk("t4_hold", 64'(cpu_hold_o),  64'd1);
    chk("t4_done", 64'(done_o),      64'd0);

    // Test 5: stall mid-word; timeout fires 16 cycles after the last byte
    tx_q.push_back(8'hA5); tx_q.push_back(8'h01); tx_q.push_back(8'h00);
    tx_q.push_back(8'h13); tx_q.push_back(8'h05);
    send_q();
    chk("t5_err_clr", 64'(error_o), 64'd0);
    repeat (15) @(posedge clk);
    #1;
    chk("t5_err_15", 64'(error_o), 64'd0);
    @(posedge clk);
    #1;
    chk("t5_err_16", 64'(error_o), 64'd1);
    chk("t5_hold",   64'(cpu_hold_o), 64'd1);
    chk("t5_nwr",    64'(wr_q.size()), 64'd0);

    // Test 6: reset mid-DATA, then a fresh frame starts at address 0
    tx_q.push_back(8'hA5); tx_q.push_back(8'h02); tx_q.push_back(8'h00);
    tx_q.push_back(8'h13); tx_q.push_back(8'h05); tx_q.push_back(8'h10); tx_q.push_back(8'h00);
    tx_q.push_back(8'h93);
    send_q();
    @(negedge clk);
    chk("t6_pre_words", 64'(words_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_addr",  64'(rom_waddr_o), 64'd0);
    chk("t6_rst_words", 64'(words_o),     64'd0);
    chk("t6_rst_hold",  64'(cpu_hold_o),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr_q.delete();
    push_frame1(csum_en, 8'h87);
    send_q();
    repeat (3) @(negedge clk);
    check_two_writes("t6");
    chk("t6_done", 64'(done_o), 64'd1);
    chk("t6_hold", 64'(cpu_hold_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
